id_ex_alu_issue: RTL and testbench
==================================

# id_ex_alu_issue

Decode-and-issue stage that drives the ALU's operand and control inputs in the MIPS32 pipeline. It decodes the ID-stage instruction into a 4-bit `ALU_Ctrl`, selects/extends operands `a`/`b`, and holds them in the ID/EX pipeline register. The register supports stall (hold), flush (bubble) and an illegal-instruction flag. It is the producing end of the ALU's `a`/`b`/`ALU_Ctrl` interface.

## Interface
- No parameters; data width fixed at 32.
- `clk` input 1: pipeline clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears the ID/EX register.
- `in_valid` input 1: ID stage holds a real instruction.
- `instr` input 32: instruction word.
- `rs_data` input 32: register-file read port for rs.
- `rt_data` input 32: register-file read port for rt.
- `stall` input 1: hold the ID/EX register.
- `flush` input 1: replace the next ID/EX content with a bubble.
- `ex_valid` output 1: EX stage holds a real instruction.
- `a` output 32: ALU operand A.
- `b` output 32: ALU operand B.
- `ALU_Ctrl` output 4: ALU operation select.
- `dst_reg` output 5: write-back register index.
- `reg_write` output 1: instruction writes the register file.
- `illegal` output 1: in_valid instruction was not decodable (one-cycle flag, registered).

## Operation
- ALU_Ctrl encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- R-type (opcode 0x00): a=rs_data, b=rt_data, dst=rd, reg_write=1. Funct mapping:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB; 0x24 → AND; 0x25 → OR; 0x27 → NOR; 0x2A → SLT.
  - Any other funct is illegal.
- I-type: a=rs_data, dst=rt.
  - addi 0x08 / addiu 0x09: ADD, b=sign-extended imm16, write.
  - slti 0x0A: SLT, b=sign-extended imm16, write.
  - andi 0x0C: AND, b=zero-extended imm16, write.
  - ori 0x0D: OR, b=zero-extended imm16, write.
  - lw 0x23: ADD, b=sign-extended imm16, write.
  - sw 0x2B: ADD, b=sign-extended imm16, no write.
  - beq 0x04: SUB, b=rt_data, no write.
- Any other opcode is illegal.
- Illegal instruction with in_valid=1:
  - Load a bubble and set `illegal`=1 for that cycle.
  - Bubble means ex_valid=0, reg_write=0, ALU_Ctrl=0000, a=b=0, dst_reg=0.
- in_valid=0: load a bubble, illegal=0.
- Writes to register 0: reg_write is forced to 0 when dst_reg=0.

## Timing
- Registered, 1-cycle latency: inputs sampled on edge N appear on the outputs after edge N.
- Per-edge priority, highest first:
  1. reset: bubble, illegal=0, asynchronous, clears immediately on assertion.
  2. flush: bubble, illegal=0; flush wins over stall.
  3. stall: all outputs hold, including `illegal`.
  4. Otherwise load the decoded values.
- Reset values: ex_valid 0, a 0, b 0, ALU_Ctrl 0000, dst_reg 0, reg_write 0, illegal 0.
- Reset deasserted mid-stream: the first edge after deassertion loads normally. No leftover state exists (no FSM; the register is the only state).
- Stall across multiple cycles: the held instruction is presented unchanged every cycle. Instruction inputs are ignored until stall drops.

## Structure
- Shared package `mips_pkg`:
  - ALU_Ctrl constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - Opcode and funct constants.
  - Bubble constant.
- Sub-module `alu_ctrl_dec` (combinational):
  - Inputs: opcode, funct.
  - Outputs: ALU_Ctrl, imm_sel (none/sext/zext), dst_sel (rd/rt), reg_write, legal.
  - Top level holds the operand mux, extension logic and the ID/EX register.

## Test plan
- Reset, then add $3,$1,$2 (0x00221820), rs=4, rt=8 → next cycle a=4, b=8, ALU_Ctrl=0010, dst=3, reg_write=1, ex_valid=1.
- addi $5,$1,-1 (0x2025FFFF), rs=4 → a=4, b=0xFFFFFFFF, ALU_Ctrl=0010. Then ori $5,$1,0xFFFF (0x3425FFFF) → b=0x0000FFFF, ALU_Ctrl=0001.
- sub/and/or/slt R-types back-to-back, rs=4, rt=8 → ALU_Ctrl 0110, 0000, 0001, 0111 on consecutive cycles. Then beq (0x10220003) → 0110, reg_write=0.
- Load add, raise stall 3 cycles while instr changes to sub → outputs hold add for 3 cycles. Assert flush+stall together → bubble next cycle.
- Opcode 0x3F with in_valid=1 → illegal=1, ex_valid=0 for one cycle. add with rd=0 → reg_write=0, ex_valid=1.
- Assert reset asynchronously mid-cycle during valid traffic → all outputs 0 before the next edge. First post-reset instruction issues normally.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - ALU control, opcode/funct constants and ID/EX word shared by the issue stage
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_sel_e;

  typedef enum logic {
    DST_RD = 1'b0,
    DST_RT = 1'b1
  } dst_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  dst;
    logic        reg_write;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational opcode/funct decode into ALU control and operand selects
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output imm_sel_e   imm_sel,
  output dst_sel_e   dst_sel,
  output logic       reg_write,
  output logic       legal
);

  always_comb begin
    alu_ctrl  = ALU_AND;
    imm_sel   = IMM_NONE;
    dst_sel   = DST_RT;
    reg_write = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dst_sel   = DST_RD;
        reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
          FN_AND:          alu_ctrl = ALU_AND;
          FN_OR:           alu_ctrl = ALU_OR;
          FN_NOR:          alu_ctrl = ALU_NOR;
          FN_SLT:          alu_ctrl = ALU_SLT;
          default: begin
            legal     = 1'b0;
            reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        alu_ctrl  = ALU_ADD;
        imm_sel   = IMM_SEXT;
        reg_write = 1'b1;
      end
      OP_SLTI: begin
        alu_ctrl  = ALU_SLT;
        imm_sel   = IMM_SEXT;
        reg_write = 1'b1;
      end
      OP_ANDI: begin
        alu_ctrl  = ALU_AND;
        imm_sel   = IMM_ZEXT;
        reg_write = 1'b1;
      end
      OP_ORI: begin
        alu_ctrl  = ALU_OR;
        imm_sel   = IMM_ZEXT;
        reg_write = 1'b1;
      end
      OP_SW: begin
        alu_ctrl = ALU_ADD;
        imm_sel  = IMM_SEXT;
      end
      OP_BEQ: begin
        // Branch compare runs through the ALU as rs - rt
        alu_ctrl = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// rtl/id_ex_alu_issue.sv - decode, operand select and ID/EX register feeding the ALU
module id_ex_alu_issue
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  ALU_Ctrl,
  output logic [4:0]  dst_reg,
  output logic        reg_write,
  output logic        illegal
);

  logic [3:0] dec_ctrl;
  imm_sel_e   dec_imm_sel;
  dst_sel_e   dec_dst_sel;
  logic       dec_reg_write;
  logic       dec_legal;
  logic [15:0] imm16;
  logic [4:0]  dec_dst;
  logic [31:0] dec_b;
  idex_t       next_word;
  idex_t       idex_q;
  logic        illegal_q;
  logic        unused_rs_field;

  // rs arrives already read from the register file, so its index is not needed here
  assign unused_rs_field = ^instr[25:21];
  assign imm16 = instr[15:0];

  alu_ctrl_dec u_dec (
    .opcode    (instr[31:26]),
    .funct     (instr[5:0]),
    .alu_ctrl  (dec_ctrl),
    .imm_sel   (dec_imm_sel),
    .dst_sel   (dec_dst_sel),
    .reg_write (dec_reg_write),
    .legal     (dec_legal)
  );

  always_comb begin
    case (dec_imm_sel)
      IMM_SEXT: dec_b = {{16{imm16[15]}}, imm16};
      IMM_ZEXT: dec_b = {16'h0000, imm16};
      default:  dec_b = rt_data;
    endcase
    dec_dst = (dec_dst_sel == DST_RD) ? instr[15:11] : instr[20:16];
  end

  always_comb begin
    next_word = IDEX_BUBBLE;
    if (in_valid && dec_legal) begin
      next_word.valid     = 1'b1;
      next_word.a         = rs_data;
      next_word.b         = dec_b;
      next_word.alu_ctrl  = dec_ctrl;
      next_word.dst       = dec_dst;
      next_word.reg_write = dec_reg_write && (dec_dst != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q    <= IDEX_BUBBLE;
      illegal_q <= 1'b0;
    end else if (flush) begin
      idex_q    <= IDEX_BUBBLE;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      idex_q    <= next_word;
      illegal_q <= in_valid && !dec_legal;
    end
  end

  assign ex_valid  = idex_q.valid;
  assign a         = idex_q.a;
  assign b         = idex_q.b;
  assign ALU_Ctrl  = idex_q.alu_ctrl;
  assign dst_reg   = idex_q.dst;
  assign reg_write = idex_q.reg_write;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb/tb_id_ex_alu_issue.sv - directed self-checking bench for the ID/EX ALU issue stage
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  ALU_Ctrl;
  logic [4:0]  dst_reg;
  logic        reg_write;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  id_ex_alu_issue dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .stall     (stall),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .a         (a),
    .b         (b),
    .ALU_Ctrl  (ALU_Ctrl),
    .dst_reg   (dst_reg),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [3:0] ec, input logic [4:0] ed,
                            input logic ew, input logic ei);
    check({tag, ".ex_valid"},  {31'd0, ex_valid},  {31'd0, v});
    check({tag, ".a"},         a,                  ea);
    check({tag, ".b"},         b,                  eb);
    check({tag, ".ALU_Ctrl"},  {28'd0, ALU_Ctrl},  {28'd0, ec});
    check({tag, ".dst_reg"},   {27'd0, dst_reg},   {27'd0, ed});
    check({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, ew});
    check({tag, ".illegal"},   {31'd0, illegal},   {31'd0, ei});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] word);
    in_valid = 1'b1;
    instr    = word;
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = 32'd0;
    rs_data = 32'd4; rt_data = 32'd8; stall = 1'b0; flush = 1'b0;
    tick();
    expect_out("reset", 0, 0, 0, 4'b0000, 0, 0, 0);
    reset = 1'b0;

    issue(32'h00221820); expect_out("add",   1, 4, 8, 4'b0010, 3, 1, 0);
    issue(32'h2025FFFF); expect_out("addi",  1, 4, 32'hFFFFFFFF, 4'b0010, 5, 1, 0);
    issue(32'h3425FFFF); expect_out("ori",   1, 4, 32'h0000FFFF, 4'b0001, 5, 1, 0);
    issue(32'h00221822); expect_out("sub",   1, 4, 8, 4'b0110, 3, 1, 0);
    issue(32'h00221824); expect_out("and",   1, 4, 8, 4'b0000, 3, 1, 0);
    issue(32'h00221825); expect_out("or",    1, 4, 8, 4'b0001, 3, 1, 0);
    issue(32'h0022182A); expect_out("slt",   1, 4, 8, 4'b0111, 3, 1, 0);
    issue(32'h10220003); expect_out("beq",   1, 4, 8, 4'b0110, 2, 0, 0);
    issue(32'h00221827); expect_out("nor",   1, 4, 8, 4'b1100, 3, 1, 0);
    issue(32'h3025FFFF); expect_out("andi",  1, 4, 32'h0000FFFF, 4'b0000, 5, 1, 0);
    issue(32'h2825FFFF); expect_out("slti",  1, 4, 32'hFFFFFFFF, 4'b0111, 5, 1, 0);
    issue(32'h8C250010); expect_out("lw",    1, 4, 32'h00000010, 4'b0010, 5, 1, 0);
    issue(32'hAC25FFF0); expect_out("sw",    1, 4, 32'hFFFFFFF0, 4'b0010, 5, 0, 0);

    issue(32'h00221820);
    stall = 1'b1;
    instr = 32'h00221822;
    rs_data = 32'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 1, 4, 8, 4'b0010, 3, 1, 0);
    end
    flush = 1'b1;
    tick(); expect_out("flush_stall", 0, 0, 0, 4'b0000, 0, 0, 0);
    stall = 1'b0; flush = 1'b0; rs_data = 32'd4;

    issue(32'hFC000000); expect_out("illegal_op", 0, 0, 0, 4'b0000, 0, 0, 1);
    stall = 1'b1; instr = 32'h00221820;
    tick(); expect_out("illegal_held", 0, 0, 0, 4'b0000, 0, 0, 1);
    stall = 1'b0;
    issue(32'h00221826); expect_out("illegal_fn", 0, 0, 0, 4'b0000, 0, 0, 1);
    issue(32'h00220020); expect_out("add_rd0",    1, 4, 8, 4'b0010, 0, 0, 0);

    in_valid = 1'b0; instr = 32'hFC000000;
    tick(); expect_out("no_valid", 0, 0, 0, 4'b0000, 0, 0, 0);

    issue(32'h00221820);
    reset = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0, 4'b0000, 0, 0, 0);
    reset = 1'b0;
    issue(32'h00221822); expect_out("post_reset", 1, 4, 8, 4'b0110, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
